// File: rtl/core_pkg.sv
// core_pkg: shared enums for the pipeline hazard controller
package core_pkg;
  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_sel_e;
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MEM_WAIT} ctrl_state_e;
endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// fwd_unit: EX operand forwarding select, MEM result preferred over WB, x0 never forwarded
module fwd_unit
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_we,
  input  logic [4:0] wb_rd,
  input  logic       wb_we,
  output logic [1:0] sel
);
  assign sel = (mem_we && mem_rd == rs && mem_rd != 5'd0) ? FWD_MEM :
               (wb_we && wb_rd == rs && wb_rd != 5'd0)    ? FWD_WB  : FWD_NONE;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencing, forwarding selects, mem-wait watchdog and perf counters
module pipeline_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [4:0]           ex_rd_i,
  input  logic                 ex_MemRead_i,
  input  logic                 ex_RegWrite_i,
  input  logic [4:0]           ex_rs1_i,
  input  logic [4:0]           ex_rs2_i,
  input  logic [4:0]           mem_rd_i,
  input  logic                 mem_RegWrite_i,
  input  logic [4:0]           wb_rd_i,
  input  logic                 wb_RegWrite_i,
  input  logic                 ex_redirect_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ready_i,
  output logic                 pc_en_o,
  output logic                 if2id_en_o,
  output logic                 id2ex_en_o,
  output logic                 ex2mem_en_o,
  output logic                 if2id_flush_o,
  output logic                 id2ex_flush_o,
  output logic [1:0]           fwd_a_o,
  output logic [1:0]           fwd_b_o,
  output logic                 bus_err_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  ctrl_state_e state, state_n, ret, ret_n, ctx;
  logic [1:0] fcnt, fcnt_n, fa, fb;
  logic [WW-1:0] wcnt, wcnt_n;
  logic lu, mw_raw, mw, stall, flush_ev;
  fwd_unit u_fwd_a (.rs(ex_rs1_i), .mem_rd(mem_rd_i), .mem_we(mem_RegWrite_i),
                    .wb_rd(wb_rd_i), .wb_we(wb_RegWrite_i), .sel(fa));
  fwd_unit u_fwd_b (.rs(ex_rs2_i), .mem_rd(mem_rd_i), .mem_we(mem_RegWrite_i),
                    .wb_rd(wb_rd_i), .wb_we(wb_RegWrite_i), .sel(fb));
  assign fwd_a_o = rst ? FWD_NONE : fa;
  assign fwd_b_o = rst ? FWD_NONE : fb;
  assign lu = ex_MemRead_i && ex_RegWrite_i && ex_rd_i != 5'd0 &&
              ((id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i));
  assign mw_raw = dmem_req_i && !dmem_ready_i;
  // once the watchdog expires the wait is treated as ready until the request drops
  assign mw = mw_raw && wcnt < WW'(TIMEOUT);
  assign wcnt_n = mw ? wcnt + 1'b1 : (mw_raw ? wcnt : '0);
  assign ctx = (state == S_MEM_WAIT) ? ret : state;
  always_comb begin
    {pc_en_o, if2id_en_o, id2ex_en_o, ex2mem_en_o} = 4'hf;
    if2id_flush_o = 1'b0;
    id2ex_flush_o = 1'b0;
    state_n = ctx;
    ret_n = ret;
    fcnt_n = fcnt;
    stall = 1'b0;
    flush_ev = 1'b0;
    if (mw) begin
      {pc_en_o, if2id_en_o, id2ex_en_o, ex2mem_en_o} = 4'h0;
      state_n = S_MEM_WAIT;
      ret_n = ctx;
      stall = 1'b1;
    end else if (ex_redirect_i) begin
      if2id_flush_o = 1'b1;
      id2ex_flush_o = 1'b1;
      flush_ev = 1'b1;
      state_n = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
      fcnt_n = 2'(FLUSH_CYC - 1);
    end else if (ctx == S_FLUSH) begin
      if2id_flush_o = 1'b1;
      fcnt_n = fcnt - 1'b1;
      state_n = (fcnt == 2'd1) ? S_RUN : S_FLUSH;
    end else if (lu) begin
      pc_en_o = 1'b0;
      if2id_en_o = 1'b0;
      id2ex_flush_o = 1'b1;
      stall = 1'b1;
    end
    if (rst) begin
      {pc_en_o, if2id_en_o, id2ex_en_o, ex2mem_en_o} = 4'h0;
      if2id_flush_o = 1'b1;
      id2ex_flush_o = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      ret <= S_RUN;
      fcnt <= '0;
      wcnt <= '0;
      bus_err_o <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      fcnt <= fcnt_n;
      wcnt <= wcnt_n;
      bus_err_o <= bus_err_o || (mw && wcnt_n == WW'(TIMEOUT));
      stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(stall);
      flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(flush_ev);
    end
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage core.
- Drives enable/flush of pc, if2id, id2ex and ex2mem pipeline registers; generates EX-stage forwarding selects; freezes the pipe on data-memory wait states.
- Runs a small FSM (run / redirect-flush / mem-wait), a memory-timeout watchdog and stall/flush performance counters.
- Sits beside the datapath in core top; pure control, no data payload.

Parameters:
- FLUSH_CYC, 2, cycles if2id is squashed after a redirect (covers imem latency); legal 1..4
- TIMEOUT, 255, max consecutive mem-wait cycles before bus_err_o
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1_i, id_rs2_i  in  5  source regs of instruction in ID
- id_use_rs1_i, id_use_rs2_i  in  1  ID instruction reads rs1/rs2
- ex_rd_i  in  5  dest reg in EX
- ex_MemRead_i, ex_RegWrite_i  in  1  EX control bits from id2ex
- ex_rs1_i, ex_rs2_i  in  5  source regs of instruction in EX
- mem_rd_i  in  5; mem_RegWrite_i  in  1  MEM-stage dest
- wb_rd_i  in  5; wb_RegWrite_i  in  1  WB-stage dest
- ex_redirect_i  in  1  taken branch or jump resolved in EX
- dmem_req_i  in  1; dmem_ready_i  in  1  data-memory handshake (MEM stage)
- pc_en_o, if2id_en_o, id2ex_en_o, ex2mem_en_o  out  1  register enables
- if2id_flush_o, id2ex_flush_o  out  1  load NOP/zero controls
- fwd_a_o, fwd_b_o  out  2  fwd_sel_e for ALU operands
- bus_err_o  out  1  sticky memory-timeout error
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH  perf counters

Behaviour:
- Reset (rst=1 at posedge): state=S_RUN, flush counter=0, wait counter=0, bus_err_o=0, both perf counters=0. Combinational outputs while rst=1: all enables 0, both flushes 1, fwd = FWD_NONE.
- Load-use hazard lu = ex_MemRead_i & ex_RegWrite_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- Memory wait mw = dmem_req_i & ~dmem_ready_i.
- Priority, evaluated each cycle: mw > ex_redirect_i > S_FLUSH > lu > normal.
  - mw: all enables 0, no flush (full freeze); stall_cnt++.
  - redirect: pc_en=1, if2id_flush=1, id2ex_flush=1, other enables 1; next state S_FLUSH with counter=FLUSH_CYC-1 (if FLUSH_CYC=1 stay S_RUN); flush_cnt++. Redirect overrides lu (dependent instr squashed).
  - S_FLUSH: if2id_flush=1, enables 1, counter--, return to S_RUN when counter reaches 0; a new redirect reloads the counter; lu ignored.
  - lu: pc_en=0, if2id_en=0, id2ex_flush=1 (bubble), ex2mem_en=1; stall_cnt++. Exactly one bubble per load-use since load leaves EX next cycle.
  - normal: all enables 1, flushes 0.
- FSM states S_RUN, S_FLUSH, S_MEM_WAIT. S_MEM_WAIT entered whenever mw; held FSM context (flush counter) frozen; exit to prior state when dmem_ready_i=1.
- Watchdog: wait counter increments each mw cycle, clears when mw=0; reaching TIMEOUT sets bus_err_o (sticky until rst) and forces exit of freeze (treat as ready).
- Forwarding (combinational, x0 never forwarded): FWD_MEM if mem_RegWrite_i & mem_rd_i==ex_rsN_i & mem_rd_i!=0; else FWD_WB under the same rule with wb; else FWD_NONE. MEM wins over WB.
- Counters wrap at 2^CNT_WIDTH.

Decomposition:
- core_pkg: typedef fwd_sel_e {FWD_NONE=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2}; typedef ctrl_state_e {S_RUN, S_FLUSH, S_MEM_WAIT}.
- Sub-module fwd_unit (purely combinational forwarding compare), instantiated twice or once with both operands.

Test Plan:
- lw x5 in EX (MemRead=1,rd=5), ID add reads rs1=5 -> one cycle pc_en=0,if2id_en=0,id2ex_flush=1; next cycle normal; stall_cnt=1.
- Same lu plus ex_redirect_i=1 same cycle -> pc_en=1, both flushes=1, no stall; FLUSH_CYC=2 gives if2id_flush high 2 cycles; flush_cnt=1.
- dmem_req=1, ready low 3 cycles -> all enables 0 exactly 3 cycles, no flush; stall_cnt=3; bus_err_o=0.
- TIMEOUT=4, ready never rises -> bus_err_o=1 after 4th wait cycle, stays 1 until rst.
- mem_rd=wb_rd=7 both RegWrite, ex_rs1=7 -> fwd_a=FWD_MEM; mem_rd=0,ex_rs2=0,wb_rd=0 -> fwd_b=FWD_NONE.
- rst asserted mid S_FLUSH -> next cycle state S_RUN, counters 0, enables follow normal rules after rst drops.
